// File: rtl/mem_responder.sv
// mem_responder
// Single-port memory responder: word RAM plus a small MMIO window behind a
// simple request / ready handshake. A request is taken in IDLE, the transfer
// fields are held while the transfer is in flight, and ready pulses for one
// cycle in RESP. Writes commit at the edge that ends RESP.
//
// Optional feature: define MEM_WAIT_EN to insert WAIT_CYCLES wait states
// (WAIT state plus a 4-bit down-counter) between acceptance and RESP.
//
// Parameters:
//   DEPTH_LOG2   log2 of RAM depth in 32-bit words
//   WAIT_CYCLES  wait states per transfer with MEM_WAIT_EN (1..15)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        transfer request (sampled in IDLE only)
//   MemWrite   1 = write, 0 = read
//   adr        byte address; adr[31:16] == 16'hFFFF selects MMIO
//   writedata  write data
//   readdata   read data, loaded on entry to RESP and held until next RESP
//   ready      one-cycle completion strobe
//   err        misaligned-access flag, only ever high together with ready
//   led        MMIO LED register (offset 0x0)
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        MemWrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err,
  output logic [15:0] led
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("mem_responder: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RESP = 2'd2;
`ifdef MEM_WAIT_EN
  localparam logic [1:0] WAIT = 2'd1;
`endif

  localparam logic [15:0] MMIO_PAGE = 16'hFFFF;
  localparam logic [15:0] OFS_LED   = 16'h0000;
  localparam logic [15:0] OFS_CYCLE = 16'h0004;

  logic [1:0]  state_reg, state_next;
  logic [31:0] adr_reg;
  logic        we_reg;
  logic [31:0] wdata_reg;
  logic [15:0] led_reg;
  logic [31:0] cycle_cnt_reg;

  // readdata is split into the RAM output register (no reset, so it can map
  // onto a block RAM output) and a resettable register for everything else;
  // src_ram_reg picks between them.
  logic        src_ram_reg;
  logic [31:0] other_q_reg;
  logic [31:0] ram_q;
  logic [31:0] ram [0:(1<<DEPTH_LOG2)-1];

  logic        accept;
  logic        enter_resp;
  logic [31:0] cur_adr;
  logic        cur_we;

  assign accept = (state_reg == IDLE) && req;

`ifdef MEM_WAIT_EN
  logic [3:0] wait_cnt_reg;

  // RESP is entered from WAIT, so the captured fields are already valid.
  assign enter_resp = (state_reg == WAIT) && (wait_cnt_reg == 4'd1);
  assign cur_adr    = adr_reg;
  assign cur_we     = we_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= 4'd0;
    end else if (accept) begin
      wait_cnt_reg <= 4'(WAIT_CYCLES);
    end else if (state_reg == WAIT) begin
      wait_cnt_reg <= wait_cnt_reg - 4'd1;
    end
  end
`else
  // RESP is entered at the acceptance edge itself, so the response is built
  // from the live inputs rather than the captured copies.
  assign enter_resp = accept;
  assign cur_adr    = adr;
  assign cur_we     = MemWrite;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
`ifdef MEM_WAIT_EN
          state_next = WAIT;
`else
          state_next = RESP;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      WAIT: if (enter_resp) state_next = RESP;
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response value as seen at the edge entering RESP.
  logic        cur_mis;
  logic        cur_mmio;
  logic        rd_use_ram;
  logic [31:0] rd_other;

  always_comb begin
    cur_mis    = (cur_adr[1:0] != 2'b00);
    cur_mmio   = (cur_adr[31:16] == MMIO_PAGE);
    rd_use_ram = !cur_we && !cur_mis && !cur_mmio;
    rd_other   = 32'd0;
    if (!cur_we && !cur_mis && cur_mmio) begin
      if (cur_adr[15:0] == OFS_LED)        rd_other = {16'd0, led_reg};
      else if (cur_adr[15:0] == OFS_CYCLE) rd_other = cycle_cnt_reg;
    end
  end

  // Commit conditions, evaluated on the captured fields during RESP.
  logic in_resp;
  logic wr_ok;
  logic ram_we;
  logic led_we;

  always_comb begin
    in_resp = (state_reg == RESP);
    wr_ok   = in_resp && we_reg && (adr_reg[1:0] == 2'b00);
    ram_we  = wr_ok && (adr_reg[31:16] != MMIO_PAGE);
    led_we  = wr_ok && (adr_reg[31:16] == MMIO_PAGE) && (adr_reg[15:0] == OFS_LED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      adr_reg       <= 32'd0;
      we_reg        <= 1'b0;
      wdata_reg     <= 32'd0;
      led_reg       <= 16'd0;
      cycle_cnt_reg <= 32'd0;
      src_ram_reg   <= 1'b0;
      other_q_reg   <= 32'd0;
    end else begin
      state_reg     <= state_next;
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (accept) begin
        adr_reg   <= adr;
        we_reg    <= MemWrite;
        wdata_reg <= writedata;
      end
      if (enter_resp) begin
        src_ram_reg <= rd_use_ram;
        other_q_reg <= rd_other;
      end
      if (led_we) led_reg <= wdata_reg[15:0];
    end
  end

  // RAM: not reset. Read (entering RESP) and write (leaving RESP) never fall
  // on the same edge. Upper address bits are dropped, so addresses alias.
  always_ff @(posedge clk) begin
    if (ram_we) ram[adr_reg[DEPTH_LOG2+1:2]] <= wdata_reg;
    if (enter_resp) ram_q <= ram[cur_adr[DEPTH_LOG2+1:2]];
  end

  assign readdata = src_ram_reg ? ram_q : other_q_reg;
  assign ready    = in_resp;
  assign err      = in_resp && (adr_reg[1:0] != 2'b00);
  assign led      = led_reg;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DEPTH_LOG2, 8, log2 of RAM depth in 32-bit words.
- WAIT_CYCLES, 2, wait states inserted per transfer when MEM_WAIT_EN is defined (legal range 1..15).

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising-edge.
- rst, in, 1, asynchronous active-high reset.
- req, in, 1, initiator transfer request.
- MemWrite, in, 1, 1 = write transfer, 0 = read transfer.
- adr, in, 32, byte address.
- writedata, in, 32, write data.
- readdata, out, 32, registered read data.
- ready, out, 1, one-cycle completion strobe.
- err, out, 1, misaligned-access flag, valid with ready.
- led, out, 16, MMIO LED register contents.

Function
REQ-003 The block SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-004 In IDLE with req=1, the block SHALL capture adr, MemWrite and writedata at the clock edge, then go to WAIT when MEM_WAIT_EN is defined, else to RESP.
REQ-005 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then go to RESP.
REQ-006 In RESP, ready SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-007 req SHALL be ignored in WAIT and RESP, and captured fields SHALL NOT change in those states.
REQ-008 A new req SHALL be accepted no earlier than the first IDLE cycle after RESP, giving back-to-back transfers a period of 2 cycles without MEM_WAIT_EN and 2+WAIT_CYCLES cycles with it.
REQ-009 A write SHALL commit at the clock edge ending RESP, and only if the access is aligned.
REQ-010 readdata SHALL be registered on entry to RESP and held until the next RESP; for a write transfer it SHALL be 0.
REQ-011 Addresses with adr[31:16] != 16'hFFFF SHALL access the RAM at word index adr[DEPTH_LOG2+1:2]. Upper address bits SHALL be ignored, so addresses alias (wrap) modulo the RAM size.
REQ-012 Addresses with adr[31:16] == 16'hFFFF SHALL access the MMIO space:
- offset 0x0: led, read/write; a write stores writedata[15:0], a read returns it zero-extended.
- offset 0x4: cycle counter, read-only; writes are ignored.
- any other offset: reads return 0, writes are ignored.
REQ-013 The cycle counter SHALL be 32 bits, increment every cycle, and wrap from 32'hFFFFFFFF to 0. A read SHALL return the value sampled at the edge entering RESP.
REQ-014 A transfer with adr[1:0] != 0 SHALL complete normally through the FSM, but with err=1 alongside ready, readdata=0 and no state modified.
REQ-015 err SHALL be 0 whenever ready is 0.

Reset
REQ-016 On rst=1 the block SHALL asynchronously set state=IDLE, ready=0, err=0, readdata=0, led=0, counter=0 and the wait counter to 0.
REQ-017 RAM contents SHALL NOT be reset.
REQ-018 Reset asserted during WAIT or RESP SHALL abort the transfer, with no write committed and no ready pulse.

Configuration
REQ-019 The macro MEM_WAIT_EN SHALL control wait states:
- defined: WAIT state and wait counter are compiled in, and transfer latency from req acceptance to ready is 1+WAIT_CYCLES cycles.
- undefined: WAIT is removed and ready asserts in the cycle after acceptance.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Without the macro, write adr=0x10 data=0xDEADBEEF, then read adr=0x10: ready 1 cycle after each req, readdata=0xDEADBEEF, err=0.
- With MEM_WAIT_EN and WAIT_CYCLES=2, read adr=0x10: ready exactly 3 cycles after acceptance, single-cycle pulse.
- Write adr=0x404 data=0x1 with DEPTH_LOG2=8, then read adr=0x4: returns 0x1 (aliasing).
- Write adr=0xFFFF0000 data=0x1234ABCD: led=0xABCD; then read 0xFFFF0004 twice: the second value is larger than the first by the transfer period.
- Write adr=0x13 data=0x55: err=1 with ready, readdata=0; a read of 0x10 afterwards is unchanged.
- Assert rst during WAIT of a write to 0x20: no ready, and adr 0x20 keeps its old value.
